// File: rtl/csr_report_pkg.sv
// csr_report_pkg
// Shared definitions for csr_result_reporter:
//   - state_t    : reporter FSM states
//   - ASCII_*    : characters used in the report messages
//   - VAL_LAST / TO_LAST : index of the final byte of each message type
//   - hex_ascii  : 4-bit nibble to uppercase ASCII hex digit
package csr_report_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_VAL = 2'd1,
        SEND_TO  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Value message: verdict, space, 8 hex digits, CR, LF (12 bytes).
    // Timeout message: 'T', 'O', CR, LF (4 bytes).
    localparam logic [3:0] VAL_LAST = 4'd11;
    localparam logic [3:0] TO_LAST  = 4'd3;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        // 'A' (8'h41) minus 10
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/csr_result_reporter.sv
// csr_result_reporter
// Watches the CPU tohost CSR, latches a sticky pass/fail verdict on the first
// nonzero value, runs a post-reset watchdog and streams an ASCII report of
// every new nonzero value (and of a watchdog expiry) to a UART transmitter.
//
// Ports:
//   clk       in   1   single clock
//   rst       in   1   synchronous, active-high reset
//   csr       in  32   CPU tohost CSR value
//   tx_data   out  8   ASCII byte to transmitter (registered)
//   tx_valid  out  1   tx_data is valid (registered)
//   tx_ready  in   1   transmitter accepts the byte this cycle
//   done      out  1   sticky: first nonzero csr seen
//   pass      out  1   sticky: first nonzero csr was exactly 1
//   fail      out  1   sticky: first nonzero csr was not 1
//   timeout   out  1   sticky: watchdog expired before done
//
// Handshake: a byte transfers on every rising edge where tx_valid && tx_ready.
// Once tx_valid is raised, tx_valid and tx_data hold steady until that
// transfer happens; tx_valid never drops without a transfer except on reset.
module csr_result_reporter
    import csr_report_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] csr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [31:0]      csr_q;
    logic [31:0]      pending_val;
    logic             pending_valid;
    logic             to_pending;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      msg_val;
    logic [3:0]       idx;
    state_t           state;

    state_t           state_n;
    logic [3:0]       idx_n;
    logic [31:0]      msg_val_n;
    logic [7:0]       tx_data_n;
    logic             tx_valid_n;
    logic             take_val;
    logic             take_to;

    logic             evt;
    logic             to_fire;

    // Byte idx of the message being sent; digits are taken MSB-first.
    function automatic logic [7:0] msg_byte(input logic is_to,
                                            input logic [3:0] i,
                                            input logic [31:0] val);
        logic [7:0]  b;
        logic [3:0]  inv;
        logic [31:0] sh;
        b   = ASCII_LF;
        inv = 4'd9 - i;
        sh  = val >> {inv, 2'b00};
        if (is_to) begin
            case (i)
                4'd0:    b = ASCII_T;
                4'd1:    b = ASCII_O;
                4'd2:    b = ASCII_CR;
                default: b = ASCII_LF;
            endcase
        end else begin
            case (i)
                4'd0:    b = (val == 32'h1) ? ASCII_P : ASCII_F;
                4'd1:    b = ASCII_SP;
                4'd10:   b = ASCII_CR;
                4'd11:   b = ASCII_LF;
                default: b = hex_ascii(sh[3:0]);
            endcase
        end
        return b;
    endfunction

    assign evt     = (csr != 32'h0) && (csr != csr_q);
    // An event in the expiry cycle wins; the !timeout term makes it one-shot.
    assign to_fire = (cnt == CNT_MAX) && !done && !timeout && !evt;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        msg_val_n  = msg_val;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        take_val   = 1'b0;
        take_to    = 1'b0;
        case (state)
            IDLE: begin
                // The first byte is loaded on the leaving edge so tx_valid
                // rises together with the state change.
                if (to_pending) begin
                    state_n    = SEND_TO;
                    idx_n      = 4'd0;
                    take_to    = 1'b1;
                    tx_data_n  = msg_byte(1'b1, 4'd0, 32'h0);
                    tx_valid_n = 1'b1;
                end else if (pending_valid) begin
                    state_n    = SEND_VAL;
                    idx_n      = 4'd0;
                    msg_val_n  = pending_val;
                    take_val   = 1'b1;
                    tx_data_n  = msg_byte(1'b0, 4'd0, pending_val);
                    tx_valid_n = 1'b1;
                end
            end
            SEND_VAL, SEND_TO: begin
                if (tx_valid && tx_ready) begin
                    if (idx == ((state == SEND_TO) ? TO_LAST : VAL_LAST)) begin
                        state_n    = IDLE;
                        idx_n      = 4'd0;
                        tx_valid_n = 1'b0;
                    end else begin
                        idx_n     = idx + 4'd1;
                        tx_data_n = msg_byte(state == SEND_TO, idx + 4'd1, msg_val);
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                tx_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 4'd0;
            msg_val       <= 32'h0;
            tx_data       <= 8'h0;
            tx_valid      <= 1'b0;
            csr_q         <= 32'h0;
            pending_val   <= 32'h0;
            pending_valid <= 1'b0;
            to_pending    <= 1'b0;
            cnt           <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            msg_val  <= msg_val_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            csr_q    <= csr;

            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            // A new event overrides the clear from the FSM taking the value.
            if (evt) begin
                pending_val   <= csr;
                pending_valid <= 1'b1;
            end else if (take_val) begin
                pending_valid <= 1'b0;
            end

            if (evt && !done) begin
                done <= 1'b1;
                pass <= (csr == 32'h1);
                fail <= (csr != 32'h1);
            end

            if (to_fire) begin
                timeout    <= 1'b1;
                to_pending <= 1'b1;
            end else if (take_to) begin
                to_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/csr_result_reporter.md
# csr_result_reporter

Synthesizable on-chip consumer of the `Riscv151` `csr` (tohost) output. It watches `csr` for a new nonzero value and latches a sticky pass/fail verdict (1 = pass, anything else = fail). It runs a post-reset cycle watchdog and streams an ASCII report byte-by-byte to a UART transmitter over a valid/ready handshake. This gives the board the same result visibility the simulation bench gets by polling `csr`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000, cycles after reset release with no nonzero `csr` before a timeout is declared.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `csr`  in  32  CPU tohost CSR value.
- `tx_data`  out  8  ASCII byte to transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts the byte this cycle.
- `done`  out  1  sticky; first nonzero `csr` seen.
- `pass`  out  1  sticky; first nonzero `csr` was exactly 1.
- `fail`  out  1  sticky; first nonzero `csr` was not 1.
- `timeout`  out  1  sticky; watchdog expired before `done`.

## Operation
- Reset value of every output is 0. Reset also clears `csr_q`, the pending buffer, the counter and the FSM.
- `csr_q` holds the previous cycle's `csr`. An event fires when `csr != 0 && csr != csr_q`.
- On an event:
  - `pending_val <= csr` and `pending_valid <= 1`. Only the latest value is kept; a newer event overwrites an unsent pending value.
  - If this is the first event, set `done`, and set either `pass` (`csr == 32'h1`) or `fail`. The verdict never changes afterwards.
- `csr` returning to 0 is not reported, but it updates `csr_q`, so a repeat of an earlier value is reported again.
- Watchdog:
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It increments every cycle out of reset and saturates.
  - When the count reaches `TIMEOUT_CYCLES` and `done` is 0 and no event fires that cycle, set `timeout` and queue the timeout message.
  - An event on the same cycle wins, and `timeout` stays 0.
  - A later event is still reported normally; `timeout` remains 1.
- Messages:
  - Value message, 12 bytes: `'P'` or `'F'` (per that value == 1), `' '`, 8 uppercase hex digits MSB-first, `8'h0D`, `8'h0A`.
  - Timeout message, 4 bytes: `'T'`, `'O'`, `8'h0D`, `8'h0A`.
- FSM states:
  - IDLE → SEND_TO if the timeout message is queued. Timeout has priority over `pending_valid`.
  - IDLE → SEND_VAL if `pending_valid`. On entry, copy `pending_val` to `msg_val` and clear `pending_valid` on the same edge; an event on that edge sets it again.
  - SEND_*: byte index `idx` advances on each `tx_valid && tx_ready`. After the last byte, return to IDLE.

## Timing
- An event sampled at edge k sets pending at k. The FSM leaves IDLE at k+1. `tx_valid` is high in the cycle after k+1.
- The first byte is therefore offered 2 cycles after `csr` changes.
- `tx_data` and `tx_valid` are registered. While `tx_valid && !tx_ready`, both hold stable.
- With `tx_ready` held at 1, bytes go out one per cycle: a value message takes 12 consecutive cycles, then 1 IDLE cycle before the next message.
- `done`/`pass`/`fail` assert at the edge that samples the event. `timeout` asserts at the edge where the count equals `TIMEOUT_CYCLES`.
- `rst` mid-message: `tx_valid` is 0 after the reset edge; the partial message is dropped and not resumed.

## Structure
- Package `csr_report_pkg`:
  - FSM state enum (IDLE, SEND_VAL, SEND_TO).
  - ASCII constants (`P`, `F`, `T`, `O`, space, CR, LF).
  - Function `hex_ascii(nibble)` mapping 0–9 to `8'h30`–`8'h39` and A–F to `8'h41`–`8'h46`.
- No sub-module. The byte mux (by `idx`) is a combinational function feeding the `tx_data` register.

## Test plan
- `csr=1` at 30 cycles after reset, `tx_ready=1` → bytes `50 20 30 30 30 30 30 30 30 31 0D 0A` on 12 consecutive cycles, first byte 2 cycles after the change; `done=1`, `pass=1`, `fail=0`.
- `csr=32'hDEADBEEE` → `"F DEADBEEE\r\n"`; `fail=1`, `pass=0`.
- Same as the first scenario with `tx_ready` toggling every cycle → `tx_data` stable whenever `valid && !ready`; 12 bytes in order, none duplicated or dropped.
- `TIMEOUT_CYCLES=100`, `csr` held at 0 → `timeout=1` at count 100, `"TO\r\n"` sent. Then `csr=1` → `"P 00000001\r\n"`, `done=1`, `timeout` still 1.
- `csr` goes 1 then 3 while the first message is sending → first message completes, then `"F 00000003\r\n"`; `pass=1` and `fail=0` remain from the first value.
- `rst` asserted at byte 5 → `tx_valid=0`, all flags 0 after the edge, no bytes until a new event.
